// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared state encodings, constants and helpers for the fetch stage
package fetch_stage_pkg;
  typedef logic [1:0] fetch_state_t;
  localparam fetch_state_t FETCH = 2'd0;
  localparam fetch_state_t HOLD = 2'd1;
  localparam fetch_state_t DISCARD = 2'd2;
  localparam logic [31:0] NOP_INSTR_DEF = 32'hF000_0000;
  localparam logic [31:0] PC_INC = 32'd4;
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & ~32'h3;
  endfunction
endpackage

// File: rtl/fetch_latch.sv
// fetch_latch: IF/ID register with rst > flush > stall > load > bubble priority
module fetch_latch
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        stall,
  input  logic        load,
  input  logic [31:0] load_instr,
  input  logic [31:0] load_pc,
  output logic [31:0] instruction,
  output logic [31:0] pc_out,
  output logic        valid
);
  // bubbles and flushes keep pc_out so decode still sees the last real PC
  always_ff @(posedge clk) begin
    if (rst) begin
      instruction <= NOP_INSTR;
      pc_out <= '0;
      valid <= 1'b0;
    end else if (flush) begin
      instruction <= NOP_INSTR;
      valid <= 1'b0;
    end else if (!stall) begin
      instruction <= load ? load_instr : NOP_INSTR;
      pc_out <= load ? load_pc : pc_out;
      valid <= load;
    end
  end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC register, imem req/ready handshake and IF/ID latch feeding decode
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] pc_out,
  output logic        valid
);
  fetch_state_t state, state_d;
  logic [31:0] pc_reg, pc_d, redir_reg, redir_d, hold_instr, hold_instr_d, hold_pc, hold_pc_d;
  logic [31:0] tgt, pc_next;
  logic xfer, load;
  // pc_reg only moves on a transfer or redirect, so it is also the outstanding address
  assign imem_req = !rst && state != HOLD;
  assign imem_addr = pc_reg;
  assign xfer = imem_req && imem_ready;
  assign tgt = word_align(branch_target);
  assign pc_next = pc_reg + PC_INC;
  assign load = !branch_taken && !stall && ((state == FETCH && xfer) || state == HOLD);
  always_comb begin
    state_d = state;
    pc_d = pc_reg;
    redir_d = redir_reg;
    hold_instr_d = hold_instr;
    hold_pc_d = hold_pc;
    case (state)
      FETCH:
        if (xfer) begin
          pc_d = branch_taken ? tgt : pc_next;
          if (!branch_taken && stall) begin
            state_d = HOLD;
            hold_instr_d = imem_rdata;
            hold_pc_d = pc_next;
          end
        end else if (branch_taken) begin
          redir_d = tgt;
          state_d = DISCARD;
        end
      HOLD:
        if (branch_taken) begin
          state_d = FETCH;
          pc_d = tgt;
          hold_instr_d = NOP_INSTR;
          hold_pc_d = '0;
        end else if (!stall) state_d = FETCH;
      DISCARD:
        if (xfer) begin
          state_d = FETCH;
          pc_d = branch_taken ? tgt : redir_reg;
        end else if (branch_taken) redir_d = tgt;
      default: state_d = FETCH;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
      pc_reg <= RESET_PC;
      redir_reg <= '0;
      hold_instr <= NOP_INSTR;
      hold_pc <= '0;
    end else begin
      state <= state_d;
      pc_reg <= pc_d;
      redir_reg <= redir_d;
      hold_instr <= hold_instr_d;
      hold_pc <= hold_pc_d;
    end
  end
  fetch_latch #(.NOP_INSTR(NOP_INSTR)) u_latch (
    .clk(clk),
    .rst(rst),
    .flush(branch_taken),
    .stall(stall),
    .load(load),
    .load_instr(state == HOLD ? hold_instr : imem_rdata),
    .load_pc(state == HOLD ? hold_pc : pc_next),
    .instruction(instruction),
    .pc_out(pc_out),
    .valid(valid)
  );
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: cycle-table scoreboard bench for fetch_stage
module tb_fetch_stage;
  localparam logic [31:0] K = 32'hA5A5_0000;
  localparam logic [31:0] N = 32'hF000_0000;
  typedef struct {logic v; logic [31:0] i; logic [31:0] p;} exp_t;
  logic clk = 1'b0, rst = 1'b1, stall = 1'b0, branch_taken = 1'b0, imem_ready = 1'b0;
  logic [31:0] branch_target = '0;
  logic imem_req, valid, req2, valid2;
  logic [31:0] imem_addr, imem_rdata, instruction, pc_out, addr2, rdata2, instr2, pc_out2;
  exp_t q[$];
  int n_chk = 0, n_err = 0;
  always #5 clk = ~clk;
  assign imem_rdata = imem_addr ^ K;
  assign rdata2 = addr2 ^ K;
  fetch_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .instruction(instruction), .pc_out(pc_out), .valid(valid)
  );
  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst), .stall(1'b0), .branch_taken(1'b0), .branch_target(32'h0),
    .imem_req(req2), .imem_addr(addr2), .imem_ready(1'b1), .imem_rdata(rdata2),
    .instruction(instr2), .pc_out(pc_out2), .valid(valid2)
  );
  function automatic logic [31:0] w(input logic [31:0] a);
    return a ^ K;
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask
  task automatic cyc(input logic s, input logic b, input logic [31:0] t, input logic r,
                     input logic er, input logic [31:0] ea,
                     input logic ev, input logic [31:0] ei, input logic [31:0] ep);
    exp_t e;
    stall = s;
    branch_taken = b;
    branch_target = t;
    imem_ready = r;
    #1;
    chk("imem_req", {31'b0, imem_req}, {31'b0, er});
    if (er) chk("imem_addr", imem_addr, ea);
    q.push_back('{ev, ei, ep});
    @(negedge clk);
    e = q.pop_front();
    chk("valid", {31'b0, valid}, {31'b0, e.v});
    chk("instruction", instruction, e.i);
    chk("pc_out", pc_out, e.p);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_req_wrap", {31'b0, req2}, 32'd0);
    chk("rst_valid", {31'b0, valid}, 32'd0);
    chk("rst_instr", instruction, N);
    chk("rst_pc_out", pc_out, 32'd0);
    rst = 1'b0;
    #1;
    chk("wrap_req", {31'b0, req2}, 32'd1);
    chk("wrap_addr0", addr2, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 1, 1, 0, 1, w(0), 4);
    chk("wrap_pc_out", pc_out2, 32'd0);
    chk("wrap_valid", {31'b0, valid2}, 32'd1);
    chk("wrap_instr", instr2, w(32'hFFFF_FFFC));
    chk("wrap_addr1", addr2, 32'd0);
    cyc(0, 0, 0, 1, 1, 4, 1, w(4), 8);
    cyc(0, 0, 0, 0, 1, 8, 0, N, 8);
    cyc(0, 0, 0, 0, 1, 8, 0, N, 8);
    cyc(0, 0, 0, 1, 1, 8, 1, w(8), 12);
    cyc(0, 0, 0, 1, 1, 12, 1, w(12), 16);
    cyc(1, 0, 0, 1, 1, 16, 1, w(12), 16);
    cyc(1, 0, 0, 1, 0, 20, 1, w(12), 16);
    cyc(1, 0, 0, 1, 0, 20, 1, w(12), 16);
    cyc(0, 0, 0, 1, 0, 20, 1, w(16), 20);
    cyc(0, 0, 0, 1, 1, 20, 1, w(20), 24);
    cyc(0, 1, 32'h103, 0, 1, 24, 0, N, 24);
    cyc(0, 0, 0, 0, 1, 24, 0, N, 24);
    cyc(0, 0, 0, 1, 1, 24, 0, N, 24);
    cyc(0, 0, 0, 1, 1, 32'h100, 1, w(32'h100), 32'h104);
    cyc(1, 1, 32'h40, 1, 1, 32'h104, 0, N, 32'h104);
    cyc(0, 0, 0, 1, 1, 32'h40, 1, w(32'h40), 32'h44);
    cyc(1, 0, 0, 1, 1, 32'h44, 1, w(32'h40), 32'h44);
    cyc(1, 1, 32'h80, 1, 0, 32'h48, 0, N, 32'h44);
    cyc(0, 0, 0, 1, 1, 32'h80, 1, w(32'h80), 32'h84);
    cyc(0, 1, 32'h200, 0, 1, 32'h84, 0, N, 32'h84);
    cyc(0, 1, 32'h301, 0, 1, 32'h84, 0, N, 32'h84);
    cyc(0, 0, 0, 1, 1, 32'h84, 0, N, 32'h84);
    cyc(0, 0, 0, 1, 1, 32'h300, 1, w(32'h300), 32'h304);
    cyc(1, 0, 0, 0, 1, 32'h304, 1, w(32'h300), 32'h304);
    cyc(0, 0, 0, 1, 1, 32'h304, 1, w(32'h304), 32'h308);
    cyc(0, 0, 0, 0, 1, 32'h308, 0, N, 32'h308);
    rst = 1'b1;
    imem_ready = 1'b1;
    #1;
    chk("midrst_req", {31'b0, imem_req}, 32'd0);
    @(negedge clk);
    chk("midrst_valid", {31'b0, valid}, 32'd0);
    chk("midrst_instr", instruction, N);
    chk("midrst_pc_out", pc_out, 32'd0);
    rst = 1'b0;
    cyc(0, 0, 0, 1, 1, 0, 1, w(0), 4);
    cyc(0, 0, 0, 1, 1, 4, 1, w(4), 8);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule
